// File: rtl/cache_line_ctrl_dm_if.sv
// cache_line_ctrl_dm_if: core, tag-store, data-RAM and BIU signals of the direct-mapped cache controller
interface cache_line_ctrl_dm_if #(
  parameter int ADDR_WID = 24,
  parameter int ENTRY_NUM = 16,
  parameter int LINE_WORDS = 8
);
  localparam int ENTRYSEL_WID = ENTRY_NUM > 1 ? $clog2(ENTRY_NUM) : 1;
  localparam int WORDSEL_WID = $clog2(LINE_WORDS);
  localparam int TAG_WID = ADDR_WID - ENTRYSEL_WID - WORDSEL_WID;
  logic core_req;
  logic core_we;
  logic [ADDR_WID-1:0] core_addr;
  logic core_flush;
  logic core_ready;
  logic tag_read;
  logic tag_wthru;
  logic tag_wback;
  logic [TAG_WID-1:0] tag_addr_tag;
  logic [ENTRYSEL_WID-1:0] tag_addr_ent;
  logic tag_valid_clear;
  logic [TAG_WID-1:0] tag_refill_tag;
  logic tag_line_refill;
  logic tag_writeback_ok;
  logic tag_line_miss;
  logic tag_replace_dirty;
  logic [TAG_WID-1:0] victim_tag;
  logic cmem_we;
  logic [ENTRYSEL_WID+WORDSEL_WID-1:0] cmem_addr;
  logic cmem_src_biu;
  logic biu_req;
  logic biu_we;
  logic [ADDR_WID-1:0] biu_addr;
  logic biu_ack;
  modport master (
    input core_req, core_we, core_addr, core_flush, tag_line_miss, tag_replace_dirty, victim_tag, biu_ack,
    output core_ready, tag_read, tag_wthru, tag_wback, tag_addr_tag, tag_addr_ent, tag_valid_clear,
    output tag_refill_tag, tag_line_refill, tag_writeback_ok, cmem_we, cmem_addr, cmem_src_biu,
    output biu_req, biu_we, biu_addr
  );
  modport slave (
    output core_req, core_we, core_addr, core_flush, tag_line_miss, tag_replace_dirty, victim_tag, biu_ack,
    input core_ready, tag_read, tag_wthru, tag_wback, tag_addr_tag, tag_addr_ent, tag_valid_clear,
    input tag_refill_tag, tag_line_refill, tag_writeback_ok, cmem_we, cmem_addr, cmem_src_biu,
    input biu_req, biu_we, biu_addr
  );
endinterface

// File: rtl/cache_line_ctrl_dm.sv
// cache_line_ctrl_dm: lookup, writeback, refill and write-through sequencing for a direct-mapped cache
module cache_line_ctrl_dm #(
  parameter int ADDR_WID = 24,
  parameter int ENTRY_NUM = 16,
  parameter int LINE_WORDS = 8,
  parameter bit WBACK_ENABLE = 1'b0
) (
  input logic clk,
  input logic rst_n,
  cache_line_ctrl_dm_if.master bus
);
  localparam int ENTRYSEL_WID = ENTRY_NUM > 1 ? $clog2(ENTRY_NUM) : 1;
  localparam int WORDSEL_WID = $clog2(LINE_WORDS);
  localparam int TAG_WID = ADDR_WID - ENTRYSEL_WID - WORDSEL_WID;
  typedef enum logic [2:0] {IDLE, WTHRU, WBACK, WB_DONE, REFILL, FILL_DONE} state_t;
  state_t state, nxt;
  logic [WORDSEL_WID-1:0] cnt, cnt_n, word;
  logic [TAG_WID-1:0] vtag, vtag_n, tag_f;
  logic [ENTRYSEL_WID-1:0] ent;
  assign tag_f = bus.core_addr[ADDR_WID-1 -: TAG_WID];
  assign ent = bus.core_addr[WORDSEL_WID +: ENTRYSEL_WID];
  assign word = bus.core_addr[WORDSEL_WID-1:0];
  assign bus.tag_addr_tag = tag_f;
  assign bus.tag_addr_ent = ent;
  assign bus.tag_refill_tag = tag_f;
  // state, beat counter and latched victim tag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      vtag <= '0;
    end else begin
      state <= nxt;
      cnt <= cnt_n;
      vtag <= vtag_n;
    end
  // next state and all strobes; the bus address selects victim or requested line by state
  always_comb begin
    nxt = state;
    cnt_n = cnt;
    vtag_n = vtag;
    bus.core_ready = 1'b0;
    bus.tag_read = 1'b0;
    bus.tag_wthru = 1'b0;
    bus.tag_wback = 1'b0;
    bus.tag_valid_clear = 1'b0;
    bus.tag_line_refill = 1'b0;
    bus.tag_writeback_ok = 1'b0;
    bus.cmem_we = 1'b0;
    bus.cmem_addr = '0;
    bus.cmem_src_biu = 1'b0;
    bus.biu_req = 1'b0;
    bus.biu_we = 1'b0;
    bus.biu_addr = '0;
    case (state)
      IDLE:
        if (bus.core_flush) begin
          bus.tag_valid_clear = 1'b1;
          bus.core_ready = 1'b1;
        end else if (bus.core_req) begin
          bus.tag_read = !bus.core_we;
          bus.tag_wthru = bus.core_we && !WBACK_ENABLE;
          bus.tag_wback = bus.core_we && WBACK_ENABLE;
          bus.cmem_addr = {ent, word};
          if (!bus.tag_line_miss) begin
            bus.core_ready = !bus.core_we || WBACK_ENABLE;
            bus.cmem_we = bus.core_we && WBACK_ENABLE;
            nxt = bus.core_we && !WBACK_ENABLE ? WTHRU : IDLE;
          end else begin
            cnt_n = '0;
            vtag_n = bus.victim_tag;
            nxt = WBACK_ENABLE && bus.tag_replace_dirty ? WBACK : REFILL;
          end
        end
      WTHRU: begin
        bus.biu_req = 1'b1;
        bus.biu_we = 1'b1;
        bus.biu_addr = bus.core_addr;
        bus.cmem_addr = {ent, word};
        bus.cmem_we = bus.biu_ack;
        bus.core_ready = bus.biu_ack;
        nxt = bus.biu_ack ? IDLE : WTHRU;
      end
      WBACK: begin
        bus.biu_req = 1'b1;
        bus.biu_we = 1'b1;
        bus.biu_addr = {vtag, ent, cnt};
        bus.cmem_addr = {ent, cnt};
        cnt_n = bus.biu_ack ? cnt + 1'b1 : cnt;
        nxt = bus.biu_ack && &cnt ? WB_DONE : WBACK;
      end
      WB_DONE: begin
        bus.tag_writeback_ok = 1'b1;
        nxt = REFILL;
      end
      REFILL: begin
        bus.biu_req = 1'b1;
        bus.biu_addr = {tag_f, ent, cnt};
        bus.cmem_addr = {ent, cnt};
        bus.cmem_we = bus.biu_ack;
        bus.cmem_src_biu = bus.biu_ack;
        cnt_n = bus.biu_ack ? cnt + 1'b1 : cnt;
        nxt = bus.biu_ack && &cnt ? FILL_DONE : REFILL;
      end
      FILL_DONE: begin
        bus.tag_line_refill = 1'b1;
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end
endmodule
